// File: rtl/mips_ctrl_pkg.sv
// Shared control encodings for the multi-cycle MIPS sequencer: FSM states,
// instruction classes and the class priority decode.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU   = 2'd0,
        CLS_LOAD  = 2'd1,
        CLS_STORE = 2'd2,
        CLS_CTRL  = 2'd3
    } class_t;

    // ctrl outranks load, load outranks store; nothing set means ALU
    function automatic class_t classify(input logic is_load, input logic is_store,
                                        input logic is_ctrl);
        class_t cls;
        if (is_ctrl) begin
            cls = CLS_CTRL;
        end else if (is_load) begin
            cls = CLS_LOAD;
        end else if (is_store) begin
            cls = CLS_STORE;
        end else begin
            cls = CLS_ALU;
        end
        return cls;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async clear on rst.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // count register, frozen once every bit is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle MIPS control sequencer: per-stage enables, memory handshakes,
// wait timeout, halt handling and busy/retire performance counters.
module stage_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_ctrl,
    input  logic             is_halt,
    output logic             IF,
    output logic             ID,
    output logic             EX,
    output logic             pc_en,
    output logic             imem_en,
    output logic             dmem_en,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t              state_r, state_nxt_s;
    class_t              class_r, class_nxt_s;
    logic [WAIT_W-1:0]   wait_r, wait_nxt_s;
    logic                timeout_s;

    // the last permitted wait cycle: another miss here means the memory is dead
    assign timeout_s = (wait_r == WAIT_W'(TIMEOUT - 1));

    // state, latched class and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            class_r <= CLS_ALU;
            wait_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            class_r <= class_nxt_s;
            wait_r  <= wait_nxt_s;
        end
    end

    // next-state and stage-enable decode; stall freezes everything
    always_comb begin
        state_nxt_s = state_r;
        class_nxt_s = class_r;
        wait_nxt_s  = wait_r;
        IF          = 1'b0;
        ID          = 1'b0;
        EX          = 1'b0;
        pc_en       = 1'b0;
        imem_en     = 1'b0;
        dmem_en     = 1'b0;
        dmem_we     = 1'b0;
        reg_we      = 1'b0;
        if (stall) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = run ? ST_FETCH : ST_IDLE;
                end
                ST_FETCH: begin
                    imem_en = 1'b1;
                    if (imem_ready) begin
                        IF          = 1'b1;
                        state_nxt_s = ST_DECODE;
                    end else if (timeout_s) begin
                        state_nxt_s = ST_ERROR;
                    end else begin
                        wait_nxt_s = wait_r + WAIT_W'(1);
                    end
                end
                ST_DECODE: begin
                    ID          = 1'b1;
                    class_nxt_s = classify(is_load, is_store, is_ctrl);
                    state_nxt_s = is_halt ? ST_HALT : ST_EXEC;
                end
                ST_EXEC: begin
                    // commit is deferred to MEM/WB so a branch target is latched first
                    EX = 1'b1;
                    if ((class_r == CLS_LOAD) || (class_r == CLS_STORE)) begin
                        state_nxt_s = ST_MEM;
                    end else begin
                        state_nxt_s = ST_WB;
                    end
                end
                ST_MEM: begin
                    dmem_en = 1'b1;
                    dmem_we = (class_r == CLS_STORE);
                    if (dmem_ready) begin
                        if (class_r == CLS_STORE) begin
                            pc_en       = 1'b1;
                            state_nxt_s = run ? ST_FETCH : ST_IDLE;
                        end else begin
                            state_nxt_s = ST_WB;
                        end
                    end else if (timeout_s) begin
                        state_nxt_s = ST_ERROR;
                    end else begin
                        wait_nxt_s = wait_r + WAIT_W'(1);
                    end
                end
                ST_WB: begin
                    pc_en       = 1'b1;
                    reg_we      = (class_r != CLS_CTRL);
                    state_nxt_s = run ? ST_FETCH : ST_IDLE;
                end
                ST_HALT: begin
                    state_nxt_s = ST_HALT;
                end
                ST_ERROR: begin
                    state_nxt_s = ST_ERROR;
                end
                default: begin
                    state_nxt_s = ST_ERROR;
                end
            endcase
        end
        if (state_nxt_s != state_r) begin
            wait_nxt_s = '0;
        end else begin
            wait_nxt_s = wait_nxt_s;
        end
    end

    assign busy   = (state_r != ST_IDLE) && (state_r != ST_HALT) && (state_r != ST_ERROR);
    assign halted = (state_r == ST_HALT);
    assign err    = (state_r == ST_ERROR);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .inc (busy),
        .cnt (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pc_en),
        .cnt (instr_cnt)
    );

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed, table-driven bench for stage_sequencer (narrow counters so
// saturation is reachable quickly).
module tb_stage_sequencer;

    localparam int CW = 6;

    logic clk, rst, run, stall, imem_ready, dmem_ready;
    logic is_load, is_store, is_ctrl, is_halt;
    logic IF, ID, EX, pc_en, imem_en, dmem_en, dmem_we, reg_we, busy, halted, err;
    logic [CW-1:0] cycle_cnt, instr_cnt;

    int checks = 0;
    int errors = 0;

    stage_sequencer #(.CNT_W(CW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .run(run), .stall(stall),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .is_load(is_load), .is_store(is_store), .is_ctrl(is_ctrl), .is_halt(is_halt),
        .IF(IF), .ID(ID), .EX(EX), .pc_en(pc_en), .imem_en(imem_en),
        .dmem_en(dmem_en), .dmem_we(dmem_we), .reg_we(reg_we),
        .busy(busy), .halted(halted), .err(err),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // input bits {run,stall,imem_ready,dmem_ready,is_load,is_store,is_ctrl,is_halt}
    localparam logic [7:0] I_RUN = 8'h80, I_STL = 8'h40, I_IRD = 8'h20, I_DRD = 8'h10;
    localparam logic [7:0] I_LD = 8'h08, I_ST = 8'h04, I_CT = 8'h02, I_HL = 8'h01;
    // output bits {IF,ID,EX,pc_en,imem_en,dmem_en,dmem_we,reg_we,busy,halted,err}
    localparam logic [10:0] O_IF = 11'h400, O_ID = 11'h200, O_EX = 11'h100, O_PC = 11'h080;
    localparam logic [10:0] O_IM = 11'h040, O_DM = 11'h020, O_WE = 11'h010, O_RW = 11'h008;
    localparam logic [10:0] O_BS = 11'h004, O_HT = 11'h002, O_ER = 11'h001;

    typedef struct packed {
        logic          do_rst;
        logic [7:0]    in;
        logic [10:0]   exp;
        logic [CW-1:0] cyc;
        logic [CW-1:0] ins;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [7:0] i, input logic [10:0] e,
                                input int c, input int n);
        vec_t v;
        v.do_rst = r;
        v.in     = i;
        v.exp    = e;
        v.cyc    = CW'(c);
        v.ins    = CW'(n);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // called at posedge+1; drives one cycle, checks at negedge, returns at next posedge+1
    task automatic step(input string name, input vec_t v);
        logic [10:0] act;
        if (v.do_rst) begin
            rst = 1'b1;
        end
        {run, stall, imem_ready, dmem_ready, is_load, is_store, is_ctrl, is_halt} = v.in;
        if (v.do_rst) begin
            #2 rst = 1'b0;
        end
        @(negedge clk);
        act = {IF, ID, EX, pc_en, imem_en, dmem_en, dmem_we, reg_we, busy, halted, err};
        chk({name, " outs"}, 32'(act), 32'(v.exp));
        chk({name, " cycle_cnt"}, 32'(cycle_cnt), 32'(v.cyc));
        chk({name, " instr_cnt"}, 32'(instr_cnt), 32'(v.ins));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {run, stall, imem_ready, dmem_ready, is_load, is_store, is_ctrl, is_halt} = 8'h00;
        @(posedge clk);
        #1;

        // ALU, load with 2 waits, store, ctrl (run drops mid-ctrl)
        tbl.push_back(mk(1'b1, I_RUN,         11'h000,              0, 0));
        tbl.push_back(mk(1'b0, I_RUN | I_IRD, O_IF | O_IM | O_BS,   0, 0));
        tbl.push_back(mk(1'b0, I_RUN,         O_ID | O_BS,          1, 0));
        tbl.push_back(mk(1'b0, I_RUN,         O_EX | O_BS,          2, 0));
        tbl.push_back(mk(1'b0, I_RUN,         O_PC | O_RW | O_BS,   3, 0));
        tbl.push_back(mk(1'b0, I_RUN | I_IRD, O_IF | O_IM | O_BS,   4, 1));
        tbl.push_back(mk(1'b0, I_RUN | I_LD,  O_ID | O_BS,          5, 1));
        tbl.push_back(mk(1'b0, I_RUN,         O_EX | O_BS,          6, 1));
        tbl.push_back(mk(1'b0, I_RUN,         O_DM | O_BS,          7, 1));
        tbl.push_back(mk(1'b0, I_RUN,         O_DM | O_BS,          8, 1));
        tbl.push_back(mk(1'b0, I_RUN | I_DRD, O_DM | O_BS,          9, 1));
        tbl.push_back(mk(1'b0, I_RUN,         O_PC | O_RW | O_BS,  10, 1));
        tbl.push_back(mk(1'b0, I_RUN | I_IRD, O_IF | O_IM | O_BS,  11, 2));
        tbl.push_back(mk(1'b0, I_RUN | I_ST,  O_ID | O_BS,         12, 2));
        tbl.push_back(mk(1'b0, I_RUN,         O_EX | O_BS,         13, 2));
        tbl.push_back(mk(1'b0, I_RUN | I_DRD, O_DM | O_WE | O_PC | O_BS, 14, 2));
        tbl.push_back(mk(1'b0, I_RUN | I_IRD, O_IF | O_IM | O_BS,  15, 3));
        tbl.push_back(mk(1'b0, I_CT | I_LD,   O_ID | O_BS,         16, 3));
        tbl.push_back(mk(1'b0, 8'h00,         O_EX | O_BS,         17, 3));
        tbl.push_back(mk(1'b0, I_DRD,         O_PC | O_BS,         18, 3));
        tbl.push_back(mk(1'b0, 8'h00,         11'h000,             19, 4));
        tbl.push_back(mk(1'b0, 8'h00,         11'h000,             19, 4));
        // stall for 3 cycles in EXEC
        tbl.push_back(mk(1'b1, I_RUN,         11'h000,              0, 0));
        tbl.push_back(mk(1'b0, I_RUN | I_IRD, O_IF | O_IM | O_BS,   0, 0));
        tbl.push_back(mk(1'b0, I_RUN,         O_ID | O_BS,          1, 0));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(1'b0, I_RUN | I_STL | I_IRD | I_DRD, O_BS, 2 + k, 0));
        end
        tbl.push_back(mk(1'b0, I_RUN,         O_EX | O_BS,          5, 0));
        tbl.push_back(mk(1'b0, 8'h00,         O_PC | O_RW | O_BS,   6, 0));
        tbl.push_back(mk(1'b0, 8'h00,         11'h000,              7, 1));
        // halt wins over ctrl; HALT absorbs
        tbl.push_back(mk(1'b1, I_RUN,         11'h000,              0, 0));
        tbl.push_back(mk(1'b0, I_RUN | I_IRD, O_IF | O_IM | O_BS,   0, 0));
        tbl.push_back(mk(1'b0, I_RUN | I_HL | I_CT, O_ID | O_BS,    1, 0));
        tbl.push_back(mk(1'b0, I_RUN | I_IRD | I_DRD, O_HT,         2, 0));
        tbl.push_back(mk(1'b0, I_RUN | I_IRD | I_DRD, O_HT,         2, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // fetch timeout: 16 wait cycles then ERROR, which absorbs
        step("to_idle", mk(1'b1, I_RUN, 11'h000, 0, 0));
        for (int i = 0; i < 16; i++) begin
            step($sformatf("to_wait%0d", i), mk(1'b0, I_RUN, O_IM | O_BS, i, 0));
        end
        step("to_err0", mk(1'b0, I_RUN | I_IRD, O_ER, 16, 0));
        step("to_err1", mk(1'b0, I_RUN | I_IRD, O_ER, 16, 0));

        // ready on the 16th would-be wait cycle still reaches DECODE
        step("rw_idle", mk(1'b1, I_RUN, 11'h000, 0, 0));
        for (int i = 0; i < 15; i++) begin
            step($sformatf("rw_wait%0d", i), mk(1'b0, I_RUN, O_IM | O_BS, i, 0));
        end
        step("rw_ready", mk(1'b0, I_RUN | I_IRD, O_IF | O_IM | O_BS, 15, 0));
        step("rw_decode", mk(1'b0, I_RUN, O_ID | O_BS, 16, 0));

        // async reset in the middle of a MEM wait
        step("ar_idle", mk(1'b1, I_RUN, 11'h000, 0, 0));
        step("ar_fetch", mk(1'b0, I_RUN | I_IRD, O_IF | O_IM | O_BS, 0, 0));
        step("ar_dec", mk(1'b0, I_RUN | I_LD, O_ID | O_BS, 1, 0));
        step("ar_exec", mk(1'b0, I_RUN, O_EX | O_BS, 2, 0));
        {run, stall, imem_ready, dmem_ready, is_load, is_store, is_ctrl, is_halt} = I_RUN;
        #2;
        chk("ar_mem dmem_en", 32'(dmem_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_rst dmem_en", 32'(dmem_en), 32'd0);
        chk("ar_rst busy", 32'(busy), 32'd0);
        chk("ar_rst cycle_cnt", 32'(cycle_cnt), 32'd0);
        chk("ar_rst instr_cnt", 32'(instr_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // saturation: 20 ALU instructions = 80 busy cycles into a 6-bit counter
        step("sat_idle", mk(1'b1, I_RUN | I_IRD, 11'h000, 0, 0));
        repeat (80) @(posedge clk);
        #1;
        chk("sat cycle_cnt", 32'(cycle_cnt), 32'd63);
        chk("sat instr_cnt", 32'(instr_cnt), 32'd20);
        chk("sat busy", 32'(busy), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
